// File: rtl/prs_checker.sv
// rtl/prs_checker.sv - self-synchronising PRBS checker with windowed BER and loss-of-lock detection.
// Optional inverted-stream lock: define PRS_CHK_INV_EN.
module prs_checker #(
  parameter int               PRS_W    = 15,
  parameter logic [PRS_W-1:0] PRS_TAPS = 15'h6000,
  parameter int               SYNC_LEN = 32,
  parameter int               WIN_W    = 16,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic [WIN_W-1:0] i_loss_thr,
  input  logic             i_vld,
  input  logic             i_sym,
  output logic             o_locked,
  output logic             o_inverted,
  output logic             o_err_vld,
  output logic             o_err,
  output logic             o_win_done,
  output logic [WIN_W-1:0] o_win_errs,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;
  localparam int CW = $clog2(((PRS_W > SYNC_LEN) ? PRS_W : SYNC_LEN) + 1);

  logic [1:0]       state_q, state_d;
  logic [PRS_W-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIN_W-1:0] win_len_q, win_len_d, thr_q, thr_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d, win_err_q, win_err_d;
  logic [WIN_W-1:0] win_errs_q, win_errs_d, win_err_inc;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d, err_cnt_q, err_cnt_d;
  logic             err_vld_q, err_vld_d, err_q, err_d, win_done_q, win_done_d;
  logic             inv_q, inv_d;
  logic             pred, sym_err;
`ifdef PRS_CHK_INV_EN
  logic [CW-1:0]    inv_cnt_q, inv_cnt_d;
`endif

  assign pred        = ^(lfsr_q & PRS_TAPS);
  assign sym_err     = i_sym ^ pred ^ inv_q;
  assign win_err_inc = (win_err_q == '1) ? win_err_q : win_err_q + WIN_W'(sym_err);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    win_len_d  = win_len_q;
    thr_d      = thr_q;
    win_cnt_d  = win_cnt_q;
    win_err_d  = win_err_q;
    win_errs_d = win_errs_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    err_vld_d  = 1'b0;
    err_d      = 1'b0;
    win_done_d = 1'b0;
    inv_d      = inv_q;
`ifdef PRS_CHK_INV_EN
    inv_cnt_d  = inv_cnt_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: if (i_vld) begin
        lfsr_d = {lfsr_q[PRS_W-2:0], i_sym};
        if (cnt_q == CW'(PRS_W - 1)) begin
          cnt_d   = '0;
          state_d = S_VERIFY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_VERIFY: if (i_vld) begin
        lfsr_d = {lfsr_q[PRS_W-2:0], i_sym};
        if (i_sym == pred) begin
          cnt_d = cnt_q + CW'(1);
`ifdef PRS_CHK_INV_EN
          inv_cnt_d = '0;
`endif
        end else begin
          cnt_d = '0;
`ifdef PRS_CHK_INV_EN
          inv_cnt_d = inv_cnt_q + CW'(1);
          if (inv_cnt_q == CW'(SYNC_LEN - 1)) inv_d = 1'b1;
`endif
        end
        if ((i_sym == pred && cnt_q == CW'(SYNC_LEN - 1)) || inv_d) begin
          state_d   = S_LOCKED;
          cnt_d     = '0;
`ifdef PRS_CHK_INV_EN
          inv_cnt_d = '0;
`endif
          bit_cnt_d = '0;
          err_cnt_d = '0;
          win_cnt_d = '0;
          win_err_d = '0;
          win_len_d = i_win_len;
          thr_d     = i_loss_thr;
        end
      end
      S_LOCKED: if (i_vld) begin
        // Flywheel: the prediction, not the received bit, feeds the LFSR so errors do not propagate.
        lfsr_d    = {lfsr_q[PRS_W-2:0], pred};
        err_vld_d = 1'b1;
        err_d     = sym_err;
        if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(sym_err);
        if (win_len_q != '0) begin
          if (win_cnt_q == win_len_q - WIN_W'(1)) begin
            win_done_d = 1'b1;
            win_errs_d = win_err_inc;
            win_cnt_d  = '0;
            win_err_d  = '0;
            win_len_d  = i_win_len;
            thr_d      = i_loss_thr;
            if (win_err_inc > thr_q) begin
              state_d = S_LOAD;
              cnt_d   = '0;
              inv_d   = 1'b0;
            end
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            win_err_d = win_err_inc;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !i_enable) begin
      state_q    <= S_IDLE;
      lfsr_q     <= '0;
      cnt_q      <= '0;
      win_len_q  <= '0;
      thr_q      <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      win_errs_q <= '0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      err_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      win_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      win_len_q  <= win_len_d;
      thr_q      <= thr_d;
      win_cnt_q  <= win_cnt_d;
      win_err_q  <= win_err_d;
      win_errs_q <= win_errs_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_vld_q  <= err_vld_d;
      err_q      <= err_d;
      win_done_q <= win_done_d;
    end
  end

`ifdef PRS_CHK_INV_EN
  always_ff @(posedge clk) begin
    if (reset || !i_enable) begin
      inv_q     <= 1'b0;
      inv_cnt_q <= '0;
    end else begin
      inv_q     <= inv_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end
`else
  assign inv_q = 1'b0;
  logic unused_inv;
  assign unused_inv = inv_d;
`endif

  assign o_locked   = (state_q == S_LOCKED);
  assign o_inverted = inv_q;
  assign o_err_vld  = err_vld_q;
  assign o_err      = err_q;
  assign o_win_done = win_done_q;
  assign o_win_errs = win_errs_q;
  assign o_bit_cnt  = bit_cnt_q;
  assign o_err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_prs_checker.sv
// tb/tb_prs_checker.sv - randomized scoreboard bench for prs_checker (default build, inversion disabled).
module tb_prs_checker;

  localparam int WIN_W    = 16;
  localparam int CNT_W    = 32;
  localparam int LOCK_BIT = 15 + 32;

  logic             clk = 1'b0;
  logic             reset, i_enable, i_vld, i_sym;
  logic [WIN_W-1:0] i_win_len, i_loss_thr;
  logic             o_locked, o_inverted, o_err_vld, o_err, o_win_done;
  logic [WIN_W-1:0] o_win_errs;
  logic [CNT_W-1:0] o_bit_cnt, o_err_cnt;

  always #5 clk = ~clk;

  prs_checker dut (
    .clk(clk), .reset(reset), .i_enable(i_enable),
    .i_win_len(i_win_len), .i_loss_thr(i_loss_thr),
    .i_vld(i_vld), .i_sym(i_sym),
    .o_locked(o_locked), .o_inverted(o_inverted),
    .o_err_vld(o_err_vld), .o_err(o_err),
    .o_win_done(o_win_done), .o_win_errs(o_win_errs),
    .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Scoreboard queues filled by the stimulus side, drained by the monitor.
  bit exp_err_q[$];
  int exp_win_q[$];

  always @(negedge clk) begin
    if (o_err_vld) begin
      if (exp_err_q.size() == 0) check("unexpected_err_vld", 1, 0);
      else check("err_bit", o_err, exp_err_q.pop_front());
    end
    if (o_win_done) begin
      if (exp_win_q.size() == 0) check("unexpected_win_done", 1, 0);
      else check("win_errs", o_win_errs, exp_win_q.pop_front());
    end
  end

  // Reference sequence: s[n] = s[n-15] ^ s[n-14].
  bit hist[$];
  function automatic bit next_prs();
    bit nb;
    nb = hist[0] ^ hist[1];
    void'(hist.pop_front());
    hist.push_back(nb);
    return nb;
  endfunction

  bit     m_locked, inv_mode;
  int     m_k, m_w, m_we, m_wl, m_thr, gap;
  longint bitc, errc;

  task automatic model_clear();
    m_locked = 0; m_k = 0; m_w = 0; m_we = 0; bitc = 0; errc = 0;
  endtask

  task automatic idle_cycle();
    i_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input bit flip);
    bit e;
    i_sym = next_prs() ^ inv_mode ^ flip;
    i_vld = 1'b1;
    if (!m_locked) begin
      if (!inv_mode) begin
        m_k++;
        if (m_k == LOCK_BIT) begin
          m_locked = 1; bitc = 0; errc = 0; m_w = 0; m_we = 0;
          m_wl = i_win_len; m_thr = i_loss_thr;
        end
      end
    end else begin
      e = flip;
      exp_err_q.push_back(e);
      bitc++;
      errc += e;
      if (m_wl != 0) begin
        m_w++;
        m_we += e;
        if (m_w == m_wl) begin
          exp_win_q.push_back(m_we);
          if (m_we > m_thr) begin m_locked = 0; m_k = 0; end
          m_w = 0; m_we = 0; m_wl = i_win_len; m_thr = i_loss_thr;
        end
      end
    end
    @(posedge clk); #1;
    i_vld = 1'b0;
    check("locked", o_locked, m_locked);
    check("bit_cnt", o_bit_cnt, bitc);
    check("err_cnt", o_err_cnt, errc);
    check("inverted", o_inverted, 0);
    repeat (gap) @(posedge clk);
    if (gap != 0) #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_locked"},   o_locked, 0);
    check({tag, "_err_vld"},  o_err_vld, 0);
    check({tag, "_win_done"}, o_win_done, 0);
    check({tag, "_win_errs"}, o_win_errs, 0);
    check({tag, "_bit_cnt"},  o_bit_cnt, 0);
    check({tag, "_err_cnt"},  o_err_cnt, 0);
  endtask

  initial begin
    int p1, p2, q;
    for (int i = 0; i < 15; i++) hist.push_back(bit'($urandom_range(0, 1)));
    hist[0] = 1'b1;
    reset = 1'b1; i_enable = 1'b1; i_vld = 1'b0; i_sym = 1'b0;
    i_win_len = 16'd1000; i_loss_thr = 16'd10;
    inv_mode = 0; gap = 0; m_wl = 0; m_thr = 0;
    model_clear();
    idle_cycle();
    idle_cycle();
    check_cleared("reset");
    reset = 1'b0;
    idle_cycle();

    // Clean stream: lock at bit 47, then two error-free windows.
    for (int i = 0; i < LOCK_BIT + 2000; i++) send_bit(1'b0);

    // Two isolated errors in one window.
    p1 = $urandom_range(1, 499);
    p2 = $urandom_range(500, 1000);
    for (int i = 0; i < 1000; i++) send_bit(m_locked && (m_w + 1 == p1 || m_w + 1 == p2));

    // Error burst above threshold -> loss of lock at window end, then relock.
    q = $urandom_range(1, 900);
    for (int i = 0; i < 1000; i++) send_bit(m_locked && (m_w + 1 >= q) && (m_w + 1 < q + 20));
    for (int i = 0; i < LOCK_BIT + 100; i++) send_bit(1'b0);

    // Reset mid-window.
    for (int i = 0; i < 300; i++) send_bit(1'b0);
    reset = 1'b1;
    idle_cycle();
    model_clear();
    check_cleared("midreset");
    reset = 1'b0;
    idle_cycle();
    for (int i = 0; i < LOCK_BIT + 50; i++) send_bit(1'b0);

    // One-cycle enable drop; relock with windows disabled at 1-in-64 cadence.
    for (int i = 0; i < 30; i++) send_bit(1'b0);
    i_enable = 1'b0;
    idle_cycle();
    model_clear();
    check_cleared("disable");
    i_enable = 1'b1;
    i_win_len = 16'd0;
    idle_cycle();
    gap = 63;
    for (int i = 0; i < LOCK_BIT + 20; i++) send_bit(1'b0);
    gap = 0;

    // Inverted stream never locks without inversion support.
    reset = 1'b1;
    idle_cycle();
    model_clear();
    reset = 1'b0;
    idle_cycle();
    inv_mode = 1;
    for (int i = 0; i < 10000; i++) send_bit(1'b0);

    idle_cycle();
    idle_cycle();
    check("err_queue_drained", exp_err_q.size(), 0);
    check("win_queue_drained", exp_win_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
